// File: rtl/button_pkg.sv
// Shared button-path types and default timing counts (debouncer and event generator).
package button_pkg;

  typedef enum logic [1:0] {
    BTN_IDLE,
    BTN_PRESSED,
    BTN_LONG
  } btn_state_t;

  // Defaults assume a 50 MHz clock.
  localparam int unsigned BTN_DEBOUNCE_COUNTS_DEF = 1_000_000;   // 20 ms
  localparam int unsigned BTN_LONG_COUNTS_DEF     = 50_000_000;  // 1 s
  localparam int unsigned BTN_REPEAT_COUNTS_DEF   = 10_000_000;  // 200 ms

endpackage

// File: rtl/button_event_gen.sv
// Turns a debounced button level into registered one-cycle UI strobes:
// press, release, short click, long press and auto-repeat while held.
module button_event_gen
  import button_pkg::*;
#(
  parameter int unsigned LONG_COUNTS   = BTN_LONG_COUNTS_DEF,
  parameter int unsigned REPEAT_COUNTS = BTN_REPEAT_COUNTS_DEF,
  parameter bit          REPEAT_EN     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic button_level,
  output logic held,
  output logic press_pulse,
  output logic release_pulse,
  output logic click_pulse,
  output logic long_press,
  output logic repeat_pulse
);

  localparam int unsigned HOLD_W = (LONG_COUNTS > 1) ? $clog2(LONG_COUNTS) : 1;
  localparam int unsigned REP_W  = (REPEAT_COUNTS > 1) ? $clog2(REPEAT_COUNTS) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_COUNTS - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_COUNTS - 1);

  if (LONG_COUNTS < 2) begin : g_bad_long
    $error("button_event_gen: LONG_COUNTS must be >= 2");
  end
  if (REPEAT_COUNTS < 1) begin : g_bad_repeat
    $error("button_event_gen: REPEAT_COUNTS must be >= 1");
  end

  btn_state_t        r_state, w_state_nxt;
  logic [HOLD_W-1:0] r_hold_cnt, w_hold_nxt;
  logic [REP_W-1:0]  r_rep_cnt, w_rep_nxt;
  logic r_held, r_press, r_release, r_click, r_long, r_repeat;
  logic w_press, w_release, w_click, w_long, w_repeat;

  // Release is tested first in every held state so it beats a coincident
  // long-press threshold or repeat terminal count.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_rep_nxt   = r_rep_cnt;
    w_press     = 1'b0;
    w_release   = 1'b0;
    w_click     = 1'b0;
    w_long      = 1'b0;
    w_repeat    = 1'b0;
    case (r_state)
      BTN_IDLE: begin
        if (button_level) begin
          w_state_nxt = BTN_PRESSED;
          w_press     = 1'b1;
          w_hold_nxt  = '0;
        end
      end
      BTN_PRESSED: begin
        if (!button_level) begin
          w_state_nxt = BTN_IDLE;
          w_release   = 1'b1;
          w_click     = 1'b1;
        end else if (r_hold_cnt == HOLD_LAST) begin
          w_state_nxt = BTN_LONG;
          w_long      = 1'b1;
          w_rep_nxt   = '0;
        end else begin
          w_hold_nxt = r_hold_cnt + 1'b1;
        end
      end
      BTN_LONG: begin
        if (!button_level) begin
          w_state_nxt = BTN_IDLE;
          w_release   = 1'b1;
        end else if (REPEAT_EN) begin
          if (r_rep_cnt == REP_LAST) begin
            w_repeat  = 1'b1;
            w_rep_nxt = '0;
          end else begin
            w_rep_nxt = r_rep_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = BTN_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= BTN_IDLE;
      r_hold_cnt <= '0;
      r_rep_cnt  <= '0;
      r_held     <= 1'b0;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
      r_click    <= 1'b0;
      r_long     <= 1'b0;
      r_repeat   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_rep_cnt  <= w_rep_nxt;
      r_held     <= (w_state_nxt != BTN_IDLE);
      r_press    <= w_press;
      r_release  <= w_release;
      r_click    <= w_click;
      r_long     <= w_long;
      r_repeat   <= w_repeat;
    end
  end

  assign held          = r_held;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign click_pulse   = r_click;
  assign long_press    = r_long;
  assign repeat_pulse  = r_repeat;

endmodule
